freepdk45_sram_1w1r_write_packer: RTL

// - Upstream feeder for the 34x128 1w1r SRAM macro, driving its write port (port 0).
// - Packs a 32-bit valid/ready word stream into 128-bit lines.
// - Issues one masked SRAM write per line, to sequential line addresses that wrap.
// - Tracks line occupancy so a downstream reader on port 1 can free lines; gives backpressure when full.

---
 rtl/freepdk45_sram_1w1r_write_packer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/freepdk45_sram_1w1r_write_packer.sv
// Packs 32-bit words into 128-bit lines and issues masked writes to the SRAM port 0 (optional PACKER_TIMEOUT_EN idle flush).
// Latency: the write is registered on the edge that completes or flushes a line. Backpressure: in_ready drops while all lines are used.
module freepdk45_sram_1w1r_write_packer #(
  parameter int DATA_WIDTH = 128,
  parameter int LANE_WIDTH = 32,
  parameter int NUM_WMASKS = 4,
  parameter int ADDR_WIDTH = 6,
  parameter int RAM_WORDS  = 34,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANE_WIDTH-1:0] in_data,
  input  logic                  flush,
  input  logic                  line_free,
  output logic                  csb0,
  output logic [NUM_WMASKS-1:0] wmask0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH:0]   lines_used,
  output logic                  flush_done
);

  localparam int LW = (NUM_WMASKS > 1) ? $clog2(NUM_WMASKS) : 1;
  localparam logic [LW-1:0]         LP_LAST_LANE = LW'(NUM_WMASKS - 1);
  localparam logic [ADDR_WIDTH-1:0] LP_LAST_ADDR = ADDR_WIDTH'(RAM_WORDS - 1);
  localparam logic [ADDR_WIDTH:0]   LP_FULL      = (ADDR_WIDTH + 1)'(RAM_WORDS);
  localparam logic [ADDR_WIDTH:0]   LP_ONE       = (ADDR_WIDTH + 1)'(1);

  logic                  r_csb0;
  logic [NUM_WMASKS-1:0] r_wmask0;
  logic [ADDR_WIDTH-1:0] r_addr0;
  logic [DATA_WIDTH-1:0] r_din0;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [ADDR_WIDTH:0]   r_lines_used;
  logic                  r_flush_done;
  logic [LW-1:0]         r_lane_cnt;
  logic [DATA_WIDTH-1:0] r_line;
  logic [NUM_WMASKS-1:0] r_mask;
  logic                  r_flush_pend;
  logic                  r_flush_user;

  logic                  w_in_ready;
  logic                  w_acc;
  logic                  w_last;
  logic                  w_serve;
  logic                  w_issue;
  logic                  w_free;
  logic                  w_to_req;
  logic [DATA_WIDTH-1:0] w_line_nxt;
  logic [NUM_WMASKS-1:0] w_mask_nxt;

  assign w_in_ready = !rst0 && (r_lines_used < LP_FULL);
  assign w_acc      = in_valid && w_in_ready;
  assign w_last     = w_acc && (r_lane_cnt == LP_LAST_LANE);
  assign w_serve    = r_flush_pend && w_in_ready;
  // A flush that lands on the same edge as a word includes that word in the write.
  assign w_issue    = w_last || (w_serve && ((r_lane_cnt != '0) || w_acc));
  assign w_free     = line_free && (r_lines_used != '0);

  always_comb begin
    w_line_nxt = r_line;
    w_mask_nxt = r_mask;
    if (w_acc) begin
      w_line_nxt[int'(r_lane_cnt) * LANE_WIDTH +: LANE_WIDTH] = in_data;
      w_mask_nxt[r_lane_cnt] = 1'b1;
    end
  end

`ifdef PACKER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_idle;
  logic          w_timeout;

  assign w_timeout = (r_idle == TW'(TIMEOUT));
  // Only raise the request once; the counter stays saturated until the issue clears it.
  assign w_to_req  = w_timeout && !r_flush_pend;

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      r_idle <= '0;
    end else if (w_acc || w_issue) begin
      r_idle <= '0;
    end else if ((r_lane_cnt != '0) && !w_timeout) begin
      r_idle <= r_idle + TW'(1);
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 0);
  assign w_to_req         = 1'b0;
`endif

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      r_csb0       <= 1'b1;
      r_wmask0     <= '0;
      r_addr0      <= '0;
      r_din0       <= '0;
      r_wr_addr    <= '0;
      r_lines_used <= '0;
      r_flush_done <= 1'b0;
      r_lane_cnt   <= '0;
      r_line       <= '0;
      r_mask       <= '0;
      r_flush_pend <= 1'b0;
      r_flush_user <= 1'b0;
    end else begin
      r_flush_pend <= flush || w_to_req || (r_flush_pend && !w_serve);
      r_flush_user <= flush || (r_flush_user && !w_serve);
      r_flush_done <= w_serve && r_flush_user;

      if (w_issue) begin
        r_csb0     <= 1'b0;
        r_wmask0   <= w_mask_nxt;
        r_addr0    <= r_wr_addr;
        r_din0     <= w_line_nxt;
        r_wr_addr  <= (r_wr_addr == LP_LAST_ADDR) ? '0 : r_wr_addr + ADDR_WIDTH'(1);
        r_lane_cnt <= '0;
        r_line     <= '0;
        r_mask     <= '0;
      end else begin
        r_csb0   <= 1'b1;
        r_wmask0 <= '0;
        if (w_acc) begin
          r_lane_cnt <= r_lane_cnt + LW'(1);
          r_line     <= w_line_nxt;
          r_mask     <= w_mask_nxt;
        end
      end

      unique case ({w_issue, w_free})
        2'b10:   r_lines_used <= r_lines_used + LP_ONE;
        2'b01:   r_lines_used <= r_lines_used - LP_ONE;
        default: r_lines_used <= r_lines_used;
      endcase
    end
  end

  assign in_ready   = w_in_ready;
  assign csb0       = r_csb0;
  assign wmask0     = r_wmask0;
  assign addr0      = r_addr0;
  assign din0       = r_din0;
  assign wr_addr    = r_wr_addr;
  assign lines_used = r_lines_used;
  assign flush_done = r_flush_done;

endmodule
